// File: rtl/neuron_pkg.sv
// Shared types and helpers for the spiking-neuron block: state encoding,
// default widths and the signed saturating add/subtract used on the membrane.
package neuron_pkg;

   localparam int ADDER_WIDTH_DEF = 16;
   localparam int VMEM_WIDTH_DEF  = 20;
   localparam int LEAK_WIDTH_DEF  = 8;
   localparam int CNT_WIDTH_DEF   = 8;

   // Wide internal width; any VMEM_WIDTH up to 62 cannot overflow here.
   localparam int SAT_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_EVAL,
      ST_FIRE
   } neu_state_e;

   // a +/- b computed wide, then clamped to the signed range of w bits.
   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input logic                    sub,
      input int unsigned             w
   );
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      r  = sub ? (a - b) : (a + b);
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (r > hi)
         return hi;
      else if (r < lo)
         return lo;
      else
         return r;
   endfunction

endpackage

// File: rtl/neuron_sat_add.sv
// Signed saturating adder/subtractor of width W; result clamps at the
// signed W-bit limits instead of wrapping.
module neuron_sat_add
   import neuron_pkg::*;
#(
   parameter int unsigned W = VMEM_WIDTH_DEF
)(
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] sum_o
);

   assign sum_o = W'(sat_add(SAT_W'($signed(a_i)), SAT_W'($signed(b_i)), sub_i, W));

endmodule

// File: rtl/neuron_spike_gen.sv
// Integrate-and-fire neuron: accumulates router sums, evaluates at timestep
// end, fires and resets. Define NEURON_LEAK_EN to add the leak port and decay.
module neuron_spike_gen
   import neuron_pkg::*;
#(
   parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
   parameter int VMEM_WIDTH  = VMEM_WIDTH_DEF,
   parameter int LEAK_WIDTH  = LEAK_WIDTH_DEF,
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF
)(
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   neu_en,
   input  logic [ADDER_WIDTH-1:0] sum_in,
   input  logic                   sum_valid,
   output logic                   sum_ready,
   input  logic [VMEM_WIDTH-1:0]  threshold,
`ifdef NEURON_LEAK_EN
   input  logic [LEAK_WIDTH-1:0]  leak,
`endif
   input  logic                   reset_mode,
   input  logic                   ts_end,
   output logic                   spike_out,
   output logic [VMEM_WIDTH-1:0]  vmem_out,
   output logic [CNT_WIDTH-1:0]   spike_cnt
);

   neu_state_e state_q, state_d;
   logic [VMEM_WIDTH-1:0] vmem_q, vmem_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  accepting;
   logic                  xfer;
   logic                  fire_ok;
   logic                  add_sub;
   logic [VMEM_WIDTH-1:0] add_b;
   logic [VMEM_WIDTH-1:0] add_r;
   logic [VMEM_WIDTH-1:0] leaked;

   assign accepting = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
   assign sum_ready = rstb && neu_en && accepting;
   assign xfer      = sum_valid && sum_ready;
   assign fire_ok   = $signed(vmem_q) >= $signed(threshold);
   assign spike_out = rstb && neu_en && (state_q == ST_FIRE);

   // One adder serves both paths: accumulate while accepting, subtract threshold in FIRE.
   assign add_sub = (state_q == ST_FIRE);
   assign add_b   = add_sub ? threshold : VMEM_WIDTH'($signed(sum_in));

   neuron_sat_add #(
      .W (VMEM_WIDTH)
   ) u_sat_add (
      .a_i   (vmem_q),
      .b_i   (add_b),
      .sub_i (add_sub),
      .sum_o (add_r)
   );

`ifdef NEURON_LEAK_EN
   logic signed [VMEM_WIDTH:0] v_ext;
   logic signed [VMEM_WIDTH:0] l_ext;

   // Decay toward zero by leak; one extra bit keeps the magnitude of the most negative value.
   always_comb begin
      v_ext  = (VMEM_WIDTH+1)'($signed(vmem_q));
      l_ext  = (VMEM_WIDTH+1)'(leak);
      leaked = '0;
      if (!v_ext[VMEM_WIDTH]) begin
         if (v_ext > l_ext)
            leaked = VMEM_WIDTH'(v_ext - l_ext);
      end else begin
         if (-v_ext > l_ext)
            leaked = VMEM_WIDTH'(v_ext + l_ext);
      end
   end
`else
   assign leaked = vmem_q;
`endif

   always_comb begin
      state_d = state_q;
      vmem_d  = vmem_q;
      cnt_d   = cnt_q;
      if (neu_en) begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (xfer) begin
                  vmem_d  = add_r;
                  state_d = ST_ACCUM;
               end
               if (ts_end)
                  state_d = ST_EVAL;
            end
            ST_EVAL: begin
               if (fire_ok) begin
                  state_d = ST_FIRE;
               end else begin
                  vmem_d  = leaked;
                  state_d = ST_IDLE;
               end
            end
            ST_FIRE: begin
               vmem_d  = reset_mode ? add_r : '0;
               cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         vmem_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vmem_q  <= vmem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign vmem_out  = vmem_q;
   assign spike_cnt = cnt_q;

endmodule

// File: doc/neuron_spike_gen.md
NEURON_SPIKE_GEN -- requirements
Module: neuron_spike_gen

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 16, meaning the width of the router sum input.
REQ-002 SHALL have parameter VMEM_WIDTH, default 20, meaning the signed membrane-potential width.
REQ-003 SHALL have parameter LEAK_WIDTH, default 8, meaning the unsigned leak-per-timestep width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, meaning the spike-counter width.
REQ-005 clk  input  1  clock.
REQ-006 rstb  input  1  reset: synchronous, active-low, sampled on posedge clk.
REQ-007 neu_en  input  1  neuron enable; when low, all state is held and no handshake is accepted.
REQ-008 sum_in  input  ADDER_WIDTH  signed sum taken from the router adder's sum_reg.
REQ-009 sum_valid  input  1  sum_in is valid this cycle.
REQ-010 sum_ready  output  1  neuron accepts sum_in; a transfer occurs when sum_valid&sum_ready.
REQ-011 threshold  input  VMEM_WIDTH  signed firing threshold, static during a timestep.
REQ-012 leak  input  LEAK_WIDTH  unsigned leak subtracted at each non-firing timestep end.
REQ-013 reset_mode  input  1  0 = reset-to-zero, 1 = reset-by-subtraction of threshold.
REQ-014 ts_end  input  1  single-cycle timestep-end strobe from control memory.
REQ-015 spike_out  output  1  single-cycle spike pulse.
REQ-016 vmem_out  output  VMEM_WIDTH  current membrane potential (register).
REQ-017 spike_cnt  output  CNT_WIDTH  saturating count of spikes since reset.

Function
REQ-018 States SHALL be IDLE, ACCUM, EVAL, FIRE; sum_ready SHALL be 1 only in IDLE/ACCUM with neu_en=1.
REQ-019 IDLE->ACCUM on the first transfer; IDLE/ACCUM->EVAL on ts_end; EVAL->FIRE if vmem>=threshold (signed), else EVAL->IDLE; FIRE->IDLE unconditionally.
REQ-020 Each transfer SHALL add sign-extended sum_in to vmem with saturation at the signed VMEM_WIDTH limits, 1-cycle latency to vmem_out.
REQ-021 A transfer coinciding with ts_end SHALL be accumulated first; EVAL compares the updated vmem.
REQ-022 ts_end outside IDLE/ACCUM SHALL be ignored; ts_end in IDLE with no transfer still enters EVAL.
REQ-023 In FIRE, spike_out SHALL be 1 for exactly that cycle; vmem SHALL become 0 (reset_mode=0) or saturate(vmem-threshold) (reset_mode=1); spike_cnt SHALL increment, holding at all-ones.
REQ-024 EVAL without firing SHALL apply leak per REQ-030/031.
REQ-025 neu_en low SHALL freeze state, vmem, and spike_cnt, force spike_out=0, and delay any pending transition.

Reset
REQ-026 On rstb=0 at posedge clk: state=IDLE, vmem_out=0, spike_cnt=0, spike_out=0, sum_ready=0 in that cycle.
REQ-027 Reset SHALL override every state including FIRE; a spike in progress SHALL be dropped and not counted.

Configuration
REQ-028 The macro SHALL be NEURON_LEAK_EN.
REQ-029 When defined, the leak port and leak logic SHALL exist.
REQ-030 With leak enabled, non-firing EVAL SHALL move vmem toward 0 by leak, clamping at 0 (positive vmem decreases, negative increases).
REQ-031 When undefined, the leak port SHALL be absent and EVAL without firing SHALL leave vmem unchanged.

Structure
REQ-032 A shared package neuron_pkg SHALL hold the state enum typedef, the default width constants, and the saturating-add function.
REQ-033 One sub-module, neuron_sat_add (signed saturating adder, VMEM_WIDTH), SHALL be instantiated for both accumulate and subtract paths.

Verification
REQ-034 Scenario 1: threshold=100, reset_mode=0, sums 40,40,30, then ts_end -> one spike_out pulse 2 cycles after ts_end; vmem_out=0; spike_cnt=1.
REQ-035 Scenario 2: threshold=100, reset_mode=1, sum 250, then ts_end -> spike; vmem_out=150.
REQ-036 Scenario 3 (NEURON_LEAK_EN): vmem=-5, leak=8, ts_end without firing -> vmem_out=0; repeat without the macro -> vmem_out=-5.
REQ-037 Scenario 4: vmem=524000, sum 32767 -> vmem_out=524287 (saturated); sum_valid held during EVAL/FIRE -> sum_ready=0 and no accumulation.
REQ-038 Scenario 5: sum 120 coincident with ts_end at threshold=100 -> fires; rstb=0 asserted in FIRE -> spike_cnt=0, vmem_out=0, state IDLE.
REQ-039 Scenario 6: 300 spikes with CNT_WIDTH=8 -> spike_cnt=255; neu_en=0 for 5 cycles mid-ACCUM -> all outputs frozen.
